pe_top: RTL and testbench
=========================

Name: pe_top

Overview:
- Minimal single-lane-group SIMD processing element with its own instruction sequencer.
- On a start pulse, it fetches 12-bit instructions from an external instruction memory, starting at PC 0.
- It loads two PE_ELEMENTS-wide vectors from two external data RAMs and performs element-wise arithmetic on them.
- The element-wise result feeds a registered two-stage adder reduction tree, whose stage outputs are exported.
- Sits between the instruction ROM and the A/B vector RAMs, inside the processor top level.

Parameters:
- OPCODE_LEN, 4, opcode field width (instruction bits [OPCODE_LEN-1:0]).
- PC_WIDTH, 12, program counter / instruction address width.
- INST_LEN, 12, instruction width; operand address is bits [INST_LEN-1:OPCODE_LEN].
- DATA_WIDTH, 32, element width.
- PE_ELEMENTS, 4, elements per vector (tree is built for 4).
- DRAM_DEPTH, 256, data RAM depth; DRAM_ADDR_WIDTH = clog2(DRAM_DEPTH) (localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- valid  in  1  start pulse; sampled only in IDLE.
- inst_read_addr  out  PC_WIDTH  instruction memory address; always equals PC.
- inst_read_data  in  INST_LEN  instruction word; combinational (same-cycle) read.
- ram_a_read_addr  out  DRAM_ADDR_WIDTH  RAM A address.
- ram_a_read_data  in  PE_ELEMENTS x DATA_WIDTH  RAM A vector, packed; element i = bits [i*DATA_WIDTH +: DATA_WIDTH]; same-cycle read.
- ram_a_rd_en  out  1  RAM A read strobe.
- ram_b_read_addr, ram_b_read_data, ram_b_rd_en  same as the RAM A ports, for RAM B.
- sum_stage_out_1  out  2 x DATA_WIDTH  reduction stage 1: [0] = c0+c1, [1] = c2+c3.
- sum_stage_out_2  out  DATA_WIDTH  reduction stage 2: stage1[0] + stage1[1].

Behaviour:
- Reset (async, rstn=0) clears everything immediately:
  - state = IDLE; PC, IR, vector registers A, B, C and both stage outputs = 0.
  - Both rd_en = 0, both read addresses = 0.
  - Reset asserted mid-program aborts the program with no pending writes.
- Instruction decode: opcode = IR[3:0]; addr = IR[11:4], resized to DRAM_ADDR_WIDTH (zero-extend or truncate).
- Opcodes:
  - 0x0 NOP.
  - 0x1 ADD: C[i] = A[i] + B[i].
  - 0x2 SUB: C[i] = A[i] - B[i].
  - 0x3 MUL: C[i] = low DATA_WIDTH bits of A[i]*B[i].
  - 0x8 STOP.
  - 0x9 FETCH_A: A <= RAM_A[addr].
  - 0xA FETCH_B: B <= RAM_B[addr].
  - All other opcodes execute as NOP.
- Arithmetic is modulo 2^DATA_WIDTH, unsigned, with no overflow flags.
- FSM states: IDLE, FETCH, EXEC.
  - IDLE: valid=1 at a clock edge -> FETCH with PC=0. valid=0 -> stay in IDLE. valid is ignored in every other state.
  - FETCH: IR <= inst_read_data -> EXEC.
  - EXEC: perform the op. STOP -> IDLE with PC=0. Otherwise PC <= PC+1 (wraps modulo 2^PC_WIDTH) -> FETCH.
  - Each instruction takes 2 cycles.
- Memory strobes:
  - During EXEC of FETCH_A, ram_a_read_addr = addr and ram_a_rd_en = 1 combinationally in that cycle; A captures ram_a_read_data at the end of that cycle.
  - FETCH_B behaves identically on the B port.
  - rd_en is 0 in all other cycles. Read addresses hold their last value.
- Reduction pipeline (free-running, registered every clock):
  - sum_stage_out_1 <= {C2+C3, C0+C1}.
  - sum_stage_out_2 <= sum_stage_out_1[0] + sum_stage_out_1[1].
  - Latency after C updates: stage 1 in 1 cycle, stage 2 in 2 cycles.
  - Outputs hold while C is stable.
- A, B and C persist across STOP/restart; only reset clears them.

Test Plan:
- Reset and idle: hold rstn=0 for 120 ns -> all outputs 0, rd_en low. Release with valid=0 -> inst_read_addr stays 0, no strobes.
- Full program: ROM = {000, 019, 01A, 001, 008}; RAM_A[1] = {A1,A2,A3,A4}, RAM_B[1] = {B1,B2,B3,B4} (MSB element first); pulse valid for 2 cycles.
  - ram_a_rd_en is high for 1 cycle with addr=1, then ram_b_rd_en likewise.
  - Result: C = {152,154,156,158} hex; sum_stage_out_1 = {2A6, 2AE}; sum_stage_out_2 = 554.
  - The FSM returns to IDLE 10 cycles after start.
- MUL/SUB wrap: A = {0,0,0,1}, B = {0,0,0,2}, SUB -> C0 = FFFFFFFF. MUL with A0 = B0 = 10000h -> C0 = 0.
- Restart: after STOP, a second valid pulse re-runs from PC 0 with identical results. Holding valid high throughout a run has no effect.
- Async reset mid-run: drop rstn during EXEC of FETCH_B -> immediate zero outputs and IDLE. No B load occurs.
- Illegal opcode 0xF behaves as NOP; PC wraps from FFF to 000 when the program never executes STOP.

Source files
------------

// File: rtl/pe_top.sv
// pe_top: single lane-group SIMD processing element with a built-in sequencer.
// Fetches 12-bit instructions from an external ROM, loads vectors from two RAMs,
// computes element-wise ADD/SUB/MUL and feeds a free-running two-stage adder tree.
module pe_top #(
    parameter int OPCODE_LEN  = 4,
    parameter int PC_WIDTH    = 12,
    parameter int INST_LEN    = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int PE_ELEMENTS = 4,
    parameter int DRAM_DEPTH  = 256
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                valid,
    output logic [PC_WIDTH-1:0]                 inst_read_addr,
    input  logic [INST_LEN-1:0]                 inst_read_data,
    output logic [$clog2(DRAM_DEPTH)-1:0]       ram_a_read_addr,
    input  logic [PE_ELEMENTS*DATA_WIDTH-1:0]   ram_a_read_data,
    output logic                                ram_a_rd_en,
    output logic [$clog2(DRAM_DEPTH)-1:0]       ram_b_read_addr,
    input  logic [PE_ELEMENTS*DATA_WIDTH-1:0]   ram_b_read_data,
    output logic                                ram_b_rd_en,
    output logic [2*DATA_WIDTH-1:0]             sum_stage_out_1,
    output logic [DATA_WIDTH-1:0]               sum_stage_out_2
);

    localparam int DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH);

    localparam logic [OPCODE_LEN-1:0] OP_ADD     = OPCODE_LEN'(4'h1);
    localparam logic [OPCODE_LEN-1:0] OP_SUB     = OPCODE_LEN'(4'h2);
    localparam logic [OPCODE_LEN-1:0] OP_MUL     = OPCODE_LEN'(4'h3);
    localparam logic [OPCODE_LEN-1:0] OP_STOP    = OPCODE_LEN'(4'h8);
    localparam logic [OPCODE_LEN-1:0] OP_FETCH_A = OPCODE_LEN'(4'h9);
    localparam logic [OPCODE_LEN-1:0] OP_FETCH_B = OPCODE_LEN'(4'hA);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

    state_t                                   state_q, state_d;
    logic [PC_WIDTH-1:0]                      pc_q, pc_d;
    logic [INST_LEN-1:0]                      ir_q, ir_d;
    logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic [DRAM_ADDR_WIDTH-1:0]               addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [1:0][DATA_WIDTH-1:0]               stage1_q, stage1_d;
    logic [DATA_WIDTH-1:0]                    stage2_q, stage2_d;
    logic                                     rd_a, rd_b;
    logic [OPCODE_LEN-1:0]                    opcode;
    logic [DRAM_ADDR_WIDTH-1:0]               opnd_addr;

    // Element-wise arithmetic, all modulo 2^DATA_WIDTH; MUL keeps the low half.
    function automatic logic [DATA_WIDTH-1:0] alu_elem(
        input logic [OPCODE_LEN-1:0] op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [2*DATA_WIDTH-1:0] prod;
        prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: return prod[DATA_WIDTH-1:0];
        endcase
    endfunction

    assign opcode    = ir_q[OPCODE_LEN-1:0];
    assign opnd_addr = DRAM_ADDR_WIDTH'(ir_q[INST_LEN-1:OPCODE_LEN]);

    // Sequencer next-state, datapath next values and memory strobes.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        rd_a     = 1'b0;
        rd_b     = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            FETCH: begin
                ir_d    = inst_read_data;
                state_d = EXEC;
            end
            EXEC: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_MUL: begin
                        for (int i = 0; i < PE_ELEMENTS; i++) begin
                            c_d[i] = alu_elem(opcode, a_q[i], b_q[i]);
                        end
                    end
                    OP_FETCH_A: begin
                        rd_a     = 1'b1;
                        addr_a_d = opnd_addr;
                        a_d      = ram_a_read_data;
                    end
                    OP_FETCH_B: begin
                        rd_b     = 1'b1;
                        addr_b_d = opnd_addr;
                        b_d      = ram_b_read_data;
                    end
                    default: ;
                endcase
                if (opcode == OP_STOP) begin
                    state_d = IDLE;
                    pc_d    = '0;
                end else begin
                    state_d = FETCH;
                    pc_d    = pc_q + PC_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reduction tree next values: pairwise sums, then the final sum.
    always_comb begin
        stage1_d    = stage1_q;
        stage1_d[0] = c_q[0] + c_q[1];
        stage1_d[1] = c_q[2] + c_q[3];
        stage2_d    = stage1_q[0] + stage1_q[1];
    end

    // All state registers; reset clears control and data alike.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    // The strobed address appears in its EXEC cycle and is then held.
    assign inst_read_addr  = pc_q;
    assign ram_a_read_addr = addr_a_d;
    assign ram_b_read_addr = addr_b_d;
    assign ram_a_rd_en     = rd_a;
    assign ram_b_rd_en     = rd_b;
    assign sum_stage_out_1 = stage1_q;
    assign sum_stage_out_2 = stage2_q;

endmodule

// File: tb/tb_pe_top.sv
// Testbench for pe_top: directed vector table plus hand-written sequences.
module tb_pe_top;

    logic           clk = 1'b0;
    logic           rstn;
    logic           valid;
    logic [11:0]    inst_read_addr;
    logic [11:0]    inst_read_data;
    logic [7:0]     ram_a_read_addr, ram_b_read_addr;
    logic [127:0]   ram_a_read_data, ram_b_read_data;
    logic           ram_a_rd_en, ram_b_rd_en;
    logic [63:0]    sum_stage_out_1;
    logic [31:0]    sum_stage_out_2;

    logic [11:0]    rom   [4096];
    logic [127:0]   ram_a [256];
    logic [127:0]   ram_b [256];

    int total = 0;
    int bad   = 0;

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [127:0] a;
        logic [127:0] b;
        logic [63:0]  s1;
        logic [31:0]  s2;
    } vec_t;

    vec_t vecs[6];

    pe_top dut (
        .clk             (clk),
        .rstn            (rstn),
        .valid           (valid),
        .inst_read_addr  (inst_read_addr),
        .inst_read_data  (inst_read_data),
        .ram_a_read_addr (ram_a_read_addr),
        .ram_a_read_data (ram_a_read_data),
        .ram_a_rd_en     (ram_a_rd_en),
        .ram_b_read_addr (ram_b_read_addr),
        .ram_b_read_data (ram_b_read_data),
        .ram_b_rd_en     (ram_b_rd_en),
        .sum_stage_out_1 (sum_stage_out_1),
        .sum_stage_out_2 (sum_stage_out_2)
    );

    always #5 clk = ~clk;

    assign inst_read_data  = rom[inst_read_addr];
    assign ram_a_read_data = ram_a[ram_a_read_addr];
    assign ram_b_read_data = ram_b[ram_b_read_addr];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 12'h000;
    endtask

    task automatic load_spec_prog();
        clear_rom();
        rom[0] = 12'h000;
        rom[1] = 12'h019;
        rom[2] = 12'h01A;
        rom[3] = 12'h001;
        rom[4] = 12'h008;
        ram_a[1] = {32'hA1, 32'hA2, 32'hA3, 32'hA4};
        ram_b[1] = {32'hB1, 32'hB2, 32'hB3, 32'hB4};
    endtask

    // Runs the reference program; hold keeps valid high for the whole run.
    task automatic full_prog(input bit hold, input bit first);
        int cnt_a = 0, cnt_b = 0, cyc_a = 0, cyc_b = 0;
        load_spec_prog();
        valid = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (n == 2 && !hold) valid = 1'b0;
            if (ram_a_rd_en) begin
                cnt_a++; cyc_a = n;
                chk("prog_a_addr", 128'(ram_a_read_addr), 128'd1);
            end
            if (ram_b_rd_en) begin
                cnt_b++; cyc_b = n;
                chk("prog_b_addr", 128'(ram_b_read_addr), 128'd1);
            end
            if (n == 9 && first) chk("prog_s1_latency", 128'(sum_stage_out_1), 128'd0);
            if (n == 10) begin
                chk("prog_pc_stop", 128'(inst_read_addr), 128'h4);
                chk("prog_s1", 128'(sum_stage_out_1), 128'({32'h2A6, 32'h2AE}));
                if (first) chk("prog_s2_latency", 128'(sum_stage_out_2), 128'd0);
                valid = 1'b0;
            end
            if (n == 11) begin
                chk("prog_pc_idle", 128'(inst_read_addr), 128'h0);
                chk("prog_s2", 128'(sum_stage_out_2), 128'h554);
            end
        end
        chk("prog_a_count", 128'(cnt_a), 128'd1);
        chk("prog_a_cycle", 128'(cyc_a), 128'd4);
        chk("prog_b_count", 128'(cnt_b), 128'd1);
        chk("prog_b_cycle", 128'(cyc_b), 128'd6);
    endtask

    initial begin
        vecs[0] = '{"add",     4'h1, {32'hA1, 32'hA2, 32'hA3, 32'hA4}, {32'hB1, 32'hB2, 32'hB3, 32'hB4},
                    {32'h2A6, 32'h2AE}, 32'h554};
        vecs[1] = '{"illegal", 4'hF, {32'h0, 32'h0, 32'h0, 32'h1}, {32'h0, 32'h0, 32'h0, 32'h2},
                    {32'h2A6, 32'h2AE}, 32'h554};
        vecs[2] = '{"sub",     4'h2, {32'h0, 32'h0, 32'h0, 32'h1}, {32'h0, 32'h0, 32'h0, 32'h2},
                    {32'h0, 32'hFFFFFFFF}, 32'hFFFFFFFF};
        vecs[3] = '{"mul",     4'h3, {32'h3, 32'h5, 32'h7, 32'h10000}, {32'h2, 32'h4, 32'h6, 32'h10000},
                    {32'h1A, 32'h2A}, 32'h44};
        vecs[4] = '{"addwrap", 4'h1, {32'hFFFFFFFF, 32'h80000000, 32'h1, 32'h2},
                    {32'h1, 32'h80000000, 32'h3, 32'h4}, {32'h0, 32'hA}, 32'hA};
        vecs[5] = '{"nop",     4'h0, {32'h9, 32'h9, 32'h9, 32'h9}, {32'h7, 32'h7, 32'h7, 32'h7},
                    {32'h0, 32'hA}, 32'hA};

        for (int i = 0; i < 256; i++) begin
            ram_a[i] = '0;
            ram_b[i] = '0;
        end
        clear_rom();
        rstn  = 1'b0;
        valid = 1'b0;

        // Reset and idle
        repeat (6) @(negedge clk);
        chk("rst_pc",     128'(inst_read_addr),  128'd0);
        chk("rst_a_addr", 128'(ram_a_read_addr), 128'd0);
        chk("rst_b_addr", 128'(ram_b_read_addr), 128'd0);
        chk("rst_rd_en",  128'({ram_a_rd_en, ram_b_rd_en}), 128'd0);
        chk("rst_s1",     128'(sum_stage_out_1), 128'd0);
        chk("rst_s2",     128'(sum_stage_out_2), 128'd0);
        repeat (6) @(negedge clk);
        rstn = 1'b1;
        begin
            int strobes = 0;
            for (int n = 0; n < 5; n++) begin
                tick();
                if (ram_a_rd_en || ram_b_rd_en) strobes++;
            end
            chk("idle_pc", 128'(inst_read_addr), 128'd0);
            chk("idle_strobes", 128'(strobes), 128'd0);
        end

        // Reference program, then a restart with valid held high
        full_prog(1'b0, 1'b1);
        full_prog(1'b1, 1'b0);

        // Vector table: FETCH_A 2, FETCH_B 2, op, STOP
        for (int v = 0; v < 6; v++) begin
            clear_rom();
            rom[0] = 12'h029;
            rom[1] = 12'h02A;
            rom[2] = {8'h00, vecs[v].op};
            rom[3] = 12'h008;
            ram_a[2] = vecs[v].a;
            ram_b[2] = vecs[v].b;
            valid = 1'b1;
            tick();
            valid = 1'b0;
            repeat (11) tick();
            chk({vecs[v].name, "_s1"},   128'(sum_stage_out_1), 128'(vecs[v].s1));
            chk({vecs[v].name, "_s2"},   128'(sum_stage_out_2), 128'(vecs[v].s2));
            chk({vecs[v].name, "_hold"}, 128'(ram_a_read_addr), 128'd2);
        end

        // Async reset during EXEC of FETCH_B
        load_spec_prog();
        valid = 1'b1;
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                tick();
                valid = 1'b0;
                if (ram_b_rd_en) seen = 1'b1;
            end
            chk("midrst_seen_b", 128'(seen), 128'd1);
        end
        #2 rstn = 1'b0;
        #1;
        chk("midrst_rd_en", 128'({ram_a_rd_en, ram_b_rd_en}), 128'd0);
        chk("midrst_pc",    128'(inst_read_addr),  128'd0);
        chk("midrst_baddr", 128'(ram_b_read_addr), 128'd0);
        chk("midrst_s1",    128'(sum_stage_out_1), 128'd0);
        chk("midrst_s2",    128'(sum_stage_out_2), 128'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("midrst_idle_pc", 128'(inst_read_addr), 128'd0);
        clear_rom();
        rom[0] = 12'h019;
        rom[1] = 12'h001;
        rom[2] = 12'h008;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (10) tick();
        chk("midrst_b_clear_s1", 128'(sum_stage_out_1), 128'({32'h143, 32'h147}));
        chk("midrst_b_clear_s2", 128'(sum_stage_out_2), 128'h28A);

        // PC wrap with illegal opcodes and no STOP
        for (int i = 0; i < 4096; i++) rom[i] = 12'h01F;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        begin
            int strobes = 0;
            for (int n = 2; n <= 8195; n++) begin
                tick();
                if (ram_a_rd_en || ram_b_rd_en) strobes++;
                if (n == 8191) chk("wrap_pc_fff", 128'(inst_read_addr), 128'hFFF);
                if (n == 8193) chk("wrap_pc_000", 128'(inst_read_addr), 128'h000);
                if (n == 8195) chk("wrap_pc_001", 128'(inst_read_addr), 128'h001);
            end
            chk("wrap_strobes", 128'(strobes), 128'd0);
            chk("wrap_s2_hold", 128'(sum_stage_out_2), 128'h28A);
        end
        rstn = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
